// File: rtl/barrel_shift_arbiter_amisha_if.sv
// Request/response bundle between two shift requesters, the result consumer
// and the shared rotate sequencer.
interface barrel_shift_arbiter_amisha_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic          req0_valid_amisha;
    logic          req0_ready_amisha;
    logic [W-1:0]  req0_data_amisha;
    logic [AW-1:0] req0_amt_amisha;
    logic          req0_dir_amisha;

    logic          req1_valid_amisha;
    logic          req1_ready_amisha;
    logic [W-1:0]  req1_data_amisha;
    logic [AW-1:0] req1_amt_amisha;
    logic          req1_dir_amisha;

    logic          rsp_valid_amisha;
    logic          rsp_ready_amisha;
    logic [W-1:0]  rsp_data_amisha;
    logic          rsp_id_amisha;

    modport master (
        output req0_valid_amisha, req0_data_amisha, req0_amt_amisha, req0_dir_amisha,
        input  req0_ready_amisha,
        output req1_valid_amisha, req1_data_amisha, req1_amt_amisha, req1_dir_amisha,
        input  req1_ready_amisha,
        input  rsp_valid_amisha, rsp_data_amisha, rsp_id_amisha,
        output rsp_ready_amisha
    );

    modport slave (
        input  req0_valid_amisha, req0_data_amisha, req0_amt_amisha, req0_dir_amisha,
        output req0_ready_amisha,
        input  req1_valid_amisha, req1_data_amisha, req1_amt_amisha, req1_dir_amisha,
        output req1_ready_amisha,
        output rsp_valid_amisha, rsp_data_amisha, rsp_id_amisha,
        input  rsp_ready_amisha
    );
endinterface

// File: rtl/barrel_shift_arbiter_amisha.sv
// Round-robin arbiter feeding one shared W-bit rotator; one operation in flight,
// result returned with the requester id over a valid/ready response channel.
module barrel_shift_arbiter_amisha #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic                          clk_amisha,
    input  logic                          reset_n_amisha,
    barrel_shift_arbiter_amisha_if.slave  bus,
    output logic                          busy_amisha
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, state_nxt;
    logic          last_grant;
    logic          grant_vld;
    logic          grant_id;
    logic          accept;
    logic          ready0;
    logic          ready1;

    logic [W-1:0]  op_data_p0;
    logic [AW-1:0] op_amt_p0;
    logic          op_dir_p0;
    logic          op_id_p0;

    logic [W-1:0]  rsp_data_p1;
    logic          rsp_id_p1;
    logic          vld_p1;

    // Left rotation is folded into a right rotation by (W - amt) mod W, which
    // is exactly the AW-bit two's complement negation of amt.
    function automatic logic [W-1:0] rotate(input logic [W-1:0] a,
                                            input logic [AW-1:0] amt,
                                            input logic dir);
        logic [AW-1:0]  r;
        logic [2*W-1:0] dbl;
        r   = dir ? (AW'(0) - amt) : amt;
        dbl = {a, a} >> r;
        return dbl[W-1:0];
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (bus.req0_valid_amisha && bus.req1_valid_amisha) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
        end else if (bus.req0_valid_amisha) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (bus.req1_valid_amisha) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    // Readies are gated by reset so they read 0 while reset is held, even
    // though the state register already sits in IDLE.
    always_comb begin
        state_nxt = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = EXEC;
                    ready0    = ~grant_id & reset_n_amisha;
                    ready1    = grant_id & reset_n_amisha;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready_amisha) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && grant_vld;

    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0: operands captured on the accepting edge
    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            op_data_p0 <= '0;
            op_amt_p0  <= '0;
            op_dir_p0  <= 1'b0;
            op_id_p0   <= 1'b0;
        end else if (accept) begin
            op_id_p0 <= grant_id;
            if (grant_id) begin
                op_data_p0 <= bus.req1_data_amisha;
                op_amt_p0  <= bus.req1_amt_amisha;
                op_dir_p0  <= bus.req1_dir_amisha;
            end else begin
                op_data_p0 <= bus.req0_data_amisha;
                op_amt_p0  <= bus.req0_amt_amisha;
                op_dir_p0  <= bus.req0_dir_amisha;
            end
        end
    end

    // Stage p1: registered rotate result, held until the consumer takes it
    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            rsp_data_p1 <= '0;
            rsp_id_p1   <= 1'b0;
            vld_p1      <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            if (state == EXEC) begin
                rsp_data_p1 <= rotate(op_data_p0, op_amt_p0, op_dir_p0);
                rsp_id_p1   <= op_id_p0;
                vld_p1      <= 1'b1;
            end else if (state == RESP && bus.rsp_ready_amisha) begin
                vld_p1     <= 1'b0;
                last_grant <= rsp_id_p1;
            end
        end
    end

    assign bus.req0_ready_amisha = ready0;
    assign bus.req1_ready_amisha = ready1;
    assign bus.rsp_valid_amisha  = vld_p1;
    assign bus.rsp_data_amisha   = rsp_data_p1;
    assign bus.rsp_id_amisha     = rsp_id_p1;
    assign busy_amisha           = (state != IDLE);

endmodule

// File: tb/tb_barrel_shift_arbiter_amisha.sv
// Self-checking bench: directed scenarios plus randomized streams scored
// against a transaction-level model of the arbiter and rotator.
module tb_barrel_shift_arbiter_amisha;

    localparam int W  = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic lg_model = 1'b1;

    barrel_shift_arbiter_amisha_if #(.W(W), .AW(AW)) bus ();

    barrel_shift_arbiter_amisha #(.W(W), .AW(AW)) dut (
        .clk_amisha     (clk),
        .reset_n_amisha (rst_n),
        .bus            (bus),
        .busy_amisha    (busy)
    );

    always #5 clk = ~clk;

    // Reference rotation: a left shift by s with wrap; right by k == left by (8-k)%8.
    function automatic logic [7:0] model_rot(input logic [7:0] a, input logic [2:0] k, input logic dir);
        int v, s, r;
        v = int'(a);
        s = dir ? int'(k) : (8 - int'(k)) % 8;
        r = ((v << s) | (v >> (8 - s))) & 255;
        return 8'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [7:0] d, input logic [2:0] a, input logic dir);
        if (p == 0) begin
            bus.req0_valid_amisha = v; bus.req0_data_amisha = d;
            bus.req0_amt_amisha = a;   bus.req0_dir_amisha = dir;
        end else begin
            bus.req1_valid_amisha = v; bus.req1_data_amisha = d;
            bus.req1_amt_amisha = a;   bus.req1_dir_amisha = dir;
        end
    endtask

    task automatic clear_inputs();
        set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
        set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
        bus.rsp_ready_amisha = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        lg_model = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 1'b1, 8'h5A, 3'd2, 1'b0);
        set_req(1, 1'b1, 8'hA5, 3'd3, 1'b1);
        bus.rsp_ready_amisha = 1'b0;
        repeat (2) tick();
        n_cmp++; if (bus.req0_ready_amisha !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready_amisha); end
        n_cmp++; if (bus.req1_ready_amisha !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b want 0", bus.req1_ready_amisha); end
        n_cmp++; if (bus.rsp_valid_amisha !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_amisha); end
        n_cmp++; if (bus.rsp_data_amisha !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 00", bus.rsp_data_amisha); end
        n_cmp++; if (bus.rsp_id_amisha !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b want 0", bus.rsp_id_amisha); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        clear_inputs();
        rst_n = 1'b1;
        lg_model = 1'b1;
        tick();
    endtask

    // One isolated operation from an idle block; bp = cycles of rsp_ready low.
    task automatic send_op(input int p, input logic [7:0] d, input logic [2:0] a, input logic dir,
                           input logic [7:0] exp_d, input int bp, input string tag);
        logic rdy_p, rdy_o;
        set_req(p, 1'b1, d, a, dir);
        #1;
        rdy_p = (p == 0) ? bus.req0_ready_amisha : bus.req1_ready_amisha;
        rdy_o = (p == 0) ? bus.req1_ready_amisha : bus.req0_ready_amisha;
        n_cmp++; if (rdy_p !== 1'b1) begin n_fail++; $display("FAIL %s_grant: ready got %b want 1", tag, rdy_p); end
        n_cmp++; if (rdy_o !== 1'b0) begin n_fail++; $display("FAIL %s_other_ready: got %b want 0", tag, rdy_o); end
        tick();
        set_req(p, 1'b0, d, a, dir);
        n_cmp++; if ({bus.req0_ready_amisha, bus.req1_ready_amisha} !== 2'b00) begin n_fail++; $display("FAIL %s_ready_pulse: got %b want 00", tag, {bus.req0_ready_amisha, bus.req1_ready_amisha}); end
        n_cmp++; if ({busy, bus.rsp_valid_amisha} !== 2'b10) begin n_fail++; $display("FAIL %s_exec: busy,rsp_valid got %b want 10", tag, {busy, bus.rsp_valid_amisha}); end
        tick();
        for (int i = 0; i <= bp; i++) begin
            n_cmp++; if (bus.rsp_valid_amisha !== 1'b1) begin n_fail++; $display("FAIL %s_rsp_valid[%0d]: got %b want 1", tag, i, bus.rsp_valid_amisha); end
            n_cmp++; if (bus.rsp_data_amisha !== exp_d) begin n_fail++; $display("FAIL %s_rsp_data[%0d]: got %h want %h", tag, i, bus.rsp_data_amisha, exp_d); end
            n_cmp++; if (bus.rsp_id_amisha !== 1'(p)) begin n_fail++; $display("FAIL %s_rsp_id[%0d]: got %b want %0d", tag, i, bus.rsp_id_amisha, p); end
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_resp[%0d]: got %b want 1", tag, i, busy); end
            if (i < bp) tick();
        end
        bus.rsp_ready_amisha = 1'b1;
        tick();
        bus.rsp_ready_amisha = 1'b0;
        n_cmp++; if ({busy, bus.rsp_valid_amisha} !== 2'b00) begin n_fail++; $display("FAIL %s_idle_after: busy,rsp_valid got %b want 00", tag, {busy, bus.rsp_valid_amisha}); end
        lg_model = 1'(p);
    endtask

    task automatic test_single();
        send_op(0, 8'hBB, 3'd5, 1'b0, 8'hDD, 0, "single");
    endtask

    task automatic test_sweep();
        logic [2:0]  amt [6] = '{3'd3, 3'd1, 3'd1, 3'd4, 3'd0, 3'd0};
        logic        dir [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0]  res [6] = '{8'h77, 8'hDD, 8'h77, 8'hBB, 8'hBB, 8'hBB};
        for (int i = 0; i < 6; i++) send_op(i % 2, 8'hBB, amt[i], dir[i], res[i], 0, $sformatf("sweep%0d", i));
    endtask

    task automatic test_backpressure();
        logic [7:0] d0;
        send_op(1, 8'h3C, 3'd2, 1'b1, 8'hF0, 4, "bp");
        // Same again, but with a request arriving while the response is held.
        set_req(1, 1'b1, 8'h81, 3'd1, 1'b0);
        tick();
        set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
        d0 = 8'($urandom);
        set_req(0, 1'b1, d0, 3'd6, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({bus.rsp_valid_amisha, bus.rsp_data_amisha, bus.rsp_id_amisha} !== {1'b1, 8'hC0, 1'b1}) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h/%b want 1/c0/1", i, bus.rsp_valid_amisha, bus.rsp_data_amisha, bus.rsp_id_amisha); end
            n_cmp++; if ({bus.req0_ready_amisha, bus.req1_ready_amisha, busy} !== 3'b001) begin n_fail++; $display("FAIL bp_readies_busy[%0d]: got %b want 001", i, {bus.req0_ready_amisha, bus.req1_ready_amisha, busy}); end
            tick();
        end
        bus.rsp_ready_amisha = 1'b1;
        tick();
        bus.rsp_ready_amisha = 1'b0;
        n_cmp++; if ({busy, bus.rsp_valid_amisha, bus.req0_ready_amisha} !== 3'b001) begin n_fail++; $display("FAIL bp_wait_grant: busy,rsp_valid,ready0 got %b want 001", {busy, bus.rsp_valid_amisha, bus.req0_ready_amisha}); end
        tick();
        set_req(0, 1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        n_cmp++; if ({bus.rsp_valid_amisha, bus.rsp_data_amisha, bus.rsp_id_amisha} !== {1'b1, model_rot(d0, 3'd6, 1'b1), 1'b0}) begin n_fail++; $display("FAIL bp_second_rsp: got %b/%h/%b want 1/%h/0", bus.rsp_valid_amisha, bus.rsp_data_amisha, bus.rsp_id_amisha, model_rot(d0, 3'd6, 1'b1)); end
        bus.rsp_ready_amisha = 1'b1;
        tick();
        bus.rsp_ready_amisha = 1'b0;
        lg_model = 1'b0;
    endtask

    // Cycle-by-cycle stream scored against a model that only knows: one op
    // outstanding at a time, response two cycles after the grant, round-robin
    // on ties, and last_grant moving on the response handshake.
    task automatic run_stream(input bit use0, input bit use1, input bit rnd, input int ngrants, input string tag);
        logic [7:0] pd [2];
        logic [2:0] pa [2];
        logic       pdr [2];
        logic       pv [2];
        bit         use_p [2];
        int         cyc, grants, last_g, gcyc;
        bit         outst, acc, hs;
        logic [7:0] exp_d;
        logic       exp_id, e0, e1, erv, gid;
        use_p[0] = use0; use_p[1] = use1;
        cyc = 0; grants = 0; last_g = -100; gcyc = 0; outst = 0;
        exp_d = 8'h00; exp_id = 1'b0; gid = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pd[p] = 8'($urandom); pa[p] = 3'($urandom); pdr[p] = 1'($urandom);
            pv[p] = use_p[p] && (rnd ? 1'($urandom) : 1'b1);
            set_req(p, pv[p], pd[p], pa[p], pdr[p]);
        end
        bus.rsp_ready_amisha = rnd ? 1'($urandom) : 1'b1;
        while ((grants < ngrants || outst) && cyc < 4000) begin
            @(negedge clk);
            erv = outst && (cyc >= gcyc + 2);
            n_cmp++; if (bus.rsp_valid_amisha !== erv) begin n_fail++; $display("FAIL %s_rsp_valid@%0d: got %b want %b", tag, cyc, bus.rsp_valid_amisha, erv); end
            if (erv) begin
                n_cmp++; if (bus.rsp_data_amisha !== exp_d) begin n_fail++; $display("FAIL %s_rsp_data@%0d: got %h want %h", tag, cyc, bus.rsp_data_amisha, exp_d); end
                n_cmp++; if (bus.rsp_id_amisha !== exp_id) begin n_fail++; $display("FAIL %s_rsp_id@%0d: got %b want %b", tag, cyc, bus.rsp_id_amisha, exp_id); end
            end
            e0 = 1'b0; e1 = 1'b0;
            if (!outst) begin
                if (pv[0] && pv[1]) begin
                    if (lg_model) e0 = 1'b1; else e1 = 1'b1;
                end else if (pv[0]) e0 = 1'b1;
                else if (pv[1]) e1 = 1'b1;
            end
            n_cmp++; if ({bus.req0_ready_amisha, bus.req1_ready_amisha} !== {e0, e1}) begin n_fail++; $display("FAIL %s_readies@%0d: got %b want %b", tag, cyc, {bus.req0_ready_amisha, bus.req1_ready_amisha}, {e0, e1}); end
            n_cmp++; if (busy !== outst) begin n_fail++; $display("FAIL %s_busy@%0d: got %b want %b", tag, cyc, busy, outst); end
            hs  = erv && bus.rsp_ready_amisha;
            acc = e0 | e1;
            if (hs) begin
                outst = 1'b0;
                lg_model = exp_id;
            end
            if (acc) begin
                gid = e1;
                if (grants > 0) begin
                    n_cmp++;
                    if (rnd ? (cyc - last_g < 3) : (cyc - last_g != 3)) begin n_fail++; $display("FAIL %s_grant_gap@%0d: got %0d want %s3", tag, cyc, cyc - last_g, rnd ? ">=" : ""); end
                end
                last_g = cyc; gcyc = cyc; outst = 1'b1;
                exp_id = gid;
                exp_d = model_rot(pd[gid], pa[gid], pdr[gid]);
                grants++;
            end
            @(posedge clk);
            #1;
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if ((acc && int'(gid) == p) || !pv[p]) begin
                    pd[p] = 8'($urandom); pa[p] = 3'($urandom); pdr[p] = 1'($urandom);
                    pv[p] = (grants < ngrants) && use_p[p] && (rnd ? 1'($urandom) : 1'b1);
                end else if (rnd || grants >= ngrants) begin
                    pv[p] = (grants < ngrants) && 1'($urandom);
                end
                set_req(p, pv[p], pd[p], pa[p], pdr[p]);
            end
            bus.rsp_ready_amisha = rnd ? 1'($urandom) : 1'b1;
        end
        n_cmp++; if (cyc >= 4000) begin n_fail++; $display("FAIL %s_timeout: cycles %0d want <4000", tag, cyc); end
        n_cmp++; if (grants != ngrants) begin n_fail++; $display("FAIL %s_grant_count: got %0d want %0d", tag, grants, ngrants); end
        clear_inputs();
        tick();
    endtask

    task automatic test_tie();
        apply_reset();
        run_stream(1'b1, 1'b1, 1'b0, 6, "tie");
    endtask

    task automatic test_stream();
        run_stream(1'b0, 1'b1, 1'b0, 5, "stream1");
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, 8'h96, 3'd3, 1'b0);
        tick();
        set_req(1, 1'b0, 8'h00, 3'd0, 1'b0);
        bus.rsp_ready_amisha = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, bus.rsp_valid_amisha} !== 2'b00) begin n_fail++; $display("FAIL rstmid_async: busy,rsp_valid got %b want 00", {busy, bus.rsp_valid_amisha}); end
        set_req(0, 1'b1, 8'h0F, 3'd4, 1'b0);
        set_req(1, 1'b1, 8'hE1, 3'd1, 1'b1);
        repeat (2) begin
            tick();
            n_cmp++; if ({bus.rsp_valid_amisha, bus.req0_ready_amisha, bus.req1_ready_amisha} !== 3'b000) begin n_fail++; $display("FAIL rstmid_held: rsp_valid,readies got %b want 000", {bus.rsp_valid_amisha, bus.req0_ready_amisha, bus.req1_ready_amisha}); end
        end
        rst_n = 1'b1;
        lg_model = 1'b1;
        #1;
        n_cmp++; if ({bus.req0_ready_amisha, bus.req1_ready_amisha} !== 2'b10) begin n_fail++; $display("FAIL rstmid_first_tie: readies got %b want 10", {bus.req0_ready_amisha, bus.req1_ready_amisha}); end
        tick();
        clear_inputs();
        tick();
        n_cmp++; if ({bus.rsp_valid_amisha, bus.rsp_data_amisha, bus.rsp_id_amisha} !== {1'b1, 8'hF0, 1'b0}) begin n_fail++; $display("FAIL rstmid_rsp: got %b/%h/%b want 1/f0/0", bus.rsp_valid_amisha, bus.rsp_data_amisha, bus.rsp_id_amisha); end
        bus.rsp_ready_amisha = 1'b1;
        tick();
        bus.rsp_ready_amisha = 1'b0;
        lg_model = 1'b0;
    endtask

    task automatic test_random();
        run_stream(1'b1, 1'b1, 1'b1, 40, "rand_both");
        run_stream(1'b1, 1'b0, 1'b1, 10, "rand_p0");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_tie();
        test_stream();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
